// File: rtl/svc_rv_mem_resp.sv
// Boot loader + instruction/data memory responder for svc_rv; imem 1-cycle, dmem 0 or 1 cycle.
// No backpressure: one fetch, one load and one store accepted every cycle.
module svc_rv_mem_resp #(
   parameter int AW       = 10,
   parameter int MEM_TYPE = 0
) (
   input  logic          clk,
   input  logic          rst,

   output logic          core_rst_n,

   input  logic          load_valid,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic          load_done,
   output logic [15:0]   load_count,
   output logic          load_err,

   input  logic          imem_arvalid,
   input  logic [31:0]   imem_araddr,
   output logic [31:0]   imem_rdata,
   output logic          imem_rvalid,

   input  logic          dmem_ren,
   input  logic [31:0]   dmem_raddr,
   output logic [31:0]   dmem_rdata,

   input  logic          dmem_we,
   input  logic [31:0]   dmem_waddr,
   input  logic [31:0]   dmem_wdata,
   input  logic [3:0]    dmem_wstrb
);

   localparam int          DEPTH = 2 ** AW;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t state;
   state_t state_nx;

   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] iidx;
   logic [AW-1:0] ridx;
   logic [AW-1:0] widx;
   logic          run;
   logic          ld_we;
   logic          st_we;

   // Upper address bits wrap and byte-offset bits are don't-care.
   logic          unused_addr_bits;
   assign unused_addr_bits = ^{imem_araddr[31:AW+2], imem_araddr[1:0],
                               dmem_raddr[31:AW+2],  dmem_raddr[1:0],
                               dmem_waddr[31:AW+2],  dmem_waddr[1:0]};

   assign iidx  = imem_araddr[AW+1:2];
   assign ridx  = dmem_raddr[AW+1:2];
   assign widx  = dmem_waddr[AW+1:2];
   assign run   = (state == ST_RUN);
   assign ld_we = !run && load_valid;
   assign st_we = run && dmem_we;

   // Boot sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_LOAD;
         core_rst_n <= 1'b0;
      end else begin
         state      <= state_nx;
         core_rst_n <= (state_nx == ST_RUN);
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_LOAD: if (load_done) state_nx = ST_RUN;
         ST_RUN:  state_nx = ST_RUN;
         default: state_nx = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         load_count <= 16'h0000;
         load_err   <= 1'b0;
      end else begin
         if (ld_we && load_count != 16'hFFFF)
            load_count <= load_count + 16'h0001;
         if (run && (load_valid || load_done))
            load_err <= 1'b1;
      end
   end

   // Single write port: loader owns it in LOAD, the core's store port in RUN.
   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem[load_addr] <= load_data;
      end else if (st_we) begin
         for (int b = 0; b < 4; b++) begin
            if (dmem_wstrb[b])
               mem[widx][8*b +: 8] <= dmem_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         imem_rvalid <= 1'b0;
         imem_rdata  <= NOP;
      end else begin
         imem_rvalid <= imem_arvalid && run;
         if (imem_arvalid && run)
            imem_rdata <= mem[iidx];
      end
   end

   // Reads sample the array before the edge's write lands, so collisions return old data.
   generate
      if (MEM_TYPE == 0) begin : g_dmem_sram
         always_comb begin
            dmem_rdata = 32'h0;
            if (dmem_ren)
               dmem_rdata = mem[ridx];
         end
      end else begin : g_dmem_bram
         always_ff @(posedge clk) begin
            if (rst)
               dmem_rdata <= 32'h0;
            else if (dmem_ren)
               dmem_rdata <= mem[ridx];
         end
      end
   endgenerate

endmodule
